// File: rtl/flash_ctrl_pkg.sv
// flash_ctrl_pkg
//   Shared definitions for the serial-flash read scheduler: FSM state
//   encodings, flash command opcodes, phase lengths and a small helper
//   for sizing counters.
//   No ports; imported by flash_read_sched.
package flash_ctrl_pkg;

   // Raw encodings are kept as plain constants so older code can still
   // compare against them; the enum below reuses the same values.
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_CMD       = 3'd1;
   localparam logic [2:0] ST_ADDR      = 3'd2;
   localparam logic [2:0] ST_DUMMY     = 3'd3;
   localparam logic [2:0] ST_FETCH_BIT = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      CMD       = ST_CMD,
      ADDR      = ST_ADDR,
      DUMMY     = ST_DUMMY,
      FETCH_BIT = ST_FETCH_BIT,
      DONE      = ST_DONE
   } state_e;

   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;
   localparam int         CMD_BITS      = 8;
   localparam int         DUMMY_BITS    = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/flash_sck_gen.sv
// flash_sck_gen
//   Bit-period timer for the serial flash. While enable is high a counter
//   runs 0..CLK_PERIOD-1 once per bit; SCK is low for the first
//   CLK_PERIOD-DUTY_THRESHOLD counts and high for the rest. With enable low
//   the counter is held at 0 and SCK stays low.
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   enable       run the bit timer (high while a bit phase is active)
//   sck          serial clock to the flash pin
//   bit_start    strobe, first cycle of a bit (cnt == 0)
//   sample       strobe, cycle in which sck rises
//   bit_end      strobe, last cycle of a bit (cnt == CLK_PERIOD-1)
module flash_sck_gen #(
   parameter int CLK_PERIOD     = 10,
   parameter int DUTY_THRESHOLD = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic sck,
   output logic bit_start,
   output logic sample,
   output logic bit_end
);

   localparam int              CW       = (CLK_PERIOD > 2) ? $clog2(CLK_PERIOD) : 1;
   localparam logic [CW-1:0]   RISE_CNT = CW'(CLK_PERIOD - DUTY_THRESHOLD);
   localparam logic [CW-1:0]   LAST_CNT = CW'(CLK_PERIOD - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || !enable)   cnt <= '0;
      else if (cnt == LAST_CNT) cnt <= '0;
      else                    cnt <= cnt + CW'(1);
   end

   assign sck       = enable && (cnt >= RISE_CNT);
   assign bit_start = enable && (cnt == '0);
   assign sample    = enable && (cnt == RISE_CNT);
   assign bit_end   = enable && (cnt == LAST_CNT);

endmodule

// File: rtl/flash_read_sched.sv
// flash_read_sched
//   Round-robin read scheduler for one serial flash. Each accepted request
//   runs CS# low, an 8-bit read command, ADDR_W address bits, optional dummy
//   cycles and DATA_W data bits, then returns the data tagged with the
//   requester index.
//   Build option: define FLASH_FAST_READ_EN to issue command 0x0B with eight
//   dummy SCK periods between address and data; otherwise command 0x03 with
//   no dummy phase.
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   req          per-requester read request (level)
//   req_addr     packed addresses, slice i belongs to req[i]
//   gnt          one-hot, one-cycle acceptance pulse
//   rsp_valid    one-cycle pulse qualifying rsp_data / rsp_id
//   rsp_data     read data, first received bit in the MSB
//   rsp_id       index of the requester being answered
//   busy         high from acceptance through rsp_valid
//   flash_cs_n   chip select (active low)
//   flash_sck    serial clock, idles low
//   flash_mosi   command/address out, MSB first
//   flash_miso   read data in
module flash_read_sched
   import flash_ctrl_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_W         = 24,
   parameter int DATA_W         = 32,
   parameter int CLK_PERIOD     = 10,
   parameter int DUTY_THRESHOLD = 5,
   localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [ID_W-1:0]           rsp_id,
   output logic                      busy,
   output logic                      flash_cs_n,
   output logic                      flash_sck,
   output logic                      flash_mosi,
   input  logic                      flash_miso
);

   localparam int TX_W = CMD_BITS + ADDR_W;
   localparam int BC_W = $clog2(max3(CMD_BITS, ADDR_W, DATA_W) + 1);
`ifdef FLASH_FAST_READ_EN
   localparam logic [7:0] READ_CMD = CMD_FAST_READ;
`else
   localparam logic [7:0] READ_CMD = CMD_READ;
`endif

   state_e           state, next_phase;
   logic [ID_W-1:0]  rr_ptr, cur_id, pick_id;
   logic             pick_vld, accept;
   logic [TX_W-1:0]  tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [BC_W-1:0]  bit_cnt;
   int               state_bits;
   logic             shifting, bit_start, sample, bit_end, last_bit;

   assign shifting = state inside {CMD, ADDR, DUMMY, FETCH_BIT};

   flash_sck_gen #(
      .CLK_PERIOD     (CLK_PERIOD),
      .DUTY_THRESHOLD (DUTY_THRESHOLD)
   ) u_sck_gen (
      .clk       (clk),
      .reset     (reset),
      .enable    (shifting),
      .sck       (flash_sck),
      .bit_start (bit_start),
      .sample    (sample),
      .bit_end   (bit_end)
   );

   // Round-robin pick: scan from rr_ptr upward; the descending loop lets
   // the closest requester to rr_ptr win the last assignment.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
            pick_vld = 1'b1;
            pick_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   assign accept = (state == IDLE) && pick_vld;

   // Phase length and successor. DUMMY is unreachable unless fast read is built.
   always_comb begin
      state_bits = 0;
      next_phase = state;
      case (state)
         CMD:       begin state_bits = CMD_BITS;   next_phase = ADDR;      end
`ifdef FLASH_FAST_READ_EN
         ADDR:      begin state_bits = ADDR_W;     next_phase = DUMMY;     end
`else
         ADDR:      begin state_bits = ADDR_W;     next_phase = FETCH_BIT; end
`endif
         DUMMY:     begin state_bits = DUMMY_BITS; next_phase = FETCH_BIT; end
         FETCH_BIT: begin state_bits = DATA_W;     next_phase = DONE;      end
         default:   begin state_bits = 0;          next_phase = state;     end
      endcase
   end

   // bit_cnt counts bits started in the current phase, so on the final
   // bit_end of a phase it equals the phase length.
   assign last_bit = bit_end && (int'(bit_cnt) == state_bits);

   // mosi is the top of the tx shifter; it is shifted on bit_end so the new
   // bit is presented in the cnt==0 cycle. Once command and address are out
   // the shifter holds zeros, which gives mosi=0 in DUMMY/FETCH/IDLE.
   assign flash_mosi = tx_sr[TX_W-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         gnt        <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_id     <= '0;
         busy       <= 1'b0;
         flash_cs_n <= 1'b1;
         rr_ptr     <= '0;
         cur_id     <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         bit_cnt    <= '0;
      end else begin
         gnt       <= '0;
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  gnt[pick_id] <= 1'b1;
                  cur_id       <= pick_id;
                  tx_sr        <= {READ_CMD, req_addr[pick_id*ADDR_W +: ADDR_W]};
                  rx_sr        <= '0;
                  bit_cnt      <= '0;
                  busy         <= 1'b1;
                  flash_cs_n   <= 1'b0;
                  rr_ptr       <= ID_W'((int'(pick_id) + 1) % NUM_REQ);
                  state        <= CMD;
               end
            end
            DONE: begin
               rsp_valid <= 1'b1;
               rsp_data  <= rx_sr;
               rsp_id    <= cur_id;
               state     <= IDLE;
            end
            default: begin
               if (bit_start && (bit_cnt != '1))
                  bit_cnt <= bit_cnt + BC_W'(1);
               if (sample && (state == FETCH_BIT))
                  rx_sr <= {rx_sr[DATA_W-2:0], flash_miso};
               if (bit_end && (state inside {CMD, ADDR}))
                  tx_sr <= {tx_sr[TX_W-2:0], 1'b0};
               if (last_bit) begin
                  bit_cnt <= '0;
                  state   <= next_phase;
                  if (next_phase == DONE) flash_cs_n <= 1'b1;
               end
            end
         endcase
         // busy covers the rsp_valid cycle; a back-to-back accept keeps it up.
         if (rsp_valid && !accept) busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_flash_read_sched.sv
// tb_flash_read_sched
//   Self-checking bench for flash_read_sched with default parameters.
//   A behavioural flash captures mosi on SCK rise and drives miso after
//   SCK fall; expected responses go into a scoreboard queue at grant time.
//   Honours FLASH_FAST_READ_EN the same way as the design.
module tb_flash_read_sched;

   localparam int NUM_REQ = 2, ADDR_W = 24, DATA_W = 32, CLK_PERIOD = 10, DUTY = 5;
`ifdef FLASH_FAST_READ_EN
   localparam int         HDR     = 40;
   localparam logic [7:0] EXP_CMD = 8'h0B;
`else
   localparam int         HDR     = 32;
   localparam logic [7:0] EXP_CMD = 8'h03;
`endif
   localparam int TOT = HDR + DATA_W;
   localparam int LAT = 1 + TOT * CLK_PERIOD;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [NUM_REQ-1:0]        req = '0;
   logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
   logic [NUM_REQ-1:0]        gnt;
   logic                      rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic [0:0]                rsp_id;
   logic                      busy, flash_cs_n, flash_sck, flash_mosi;
   logic                      flash_miso = 1'b0;

   typedef struct {
      int                id;
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
      int                due;
   } exp_t;
   exp_t sb[$];

   int checks = 0, errors = 0, cyc = 0, tb_rr = 0;
   logic [DATA_W-1:0] flash_data = '0;
   int                rise_cnt = 0;
   logic [TOT-1:0]    cap = '0;

   flash_read_sched dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_addr   (req_addr),
      .gnt        (gnt),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .busy       (busy),
      .flash_cs_n (flash_cs_n),
      .flash_sck  (flash_sck),
      .flash_mosi (flash_mosi),
      .flash_miso (flash_miso)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Flash model: CS# fall starts a transaction, every SCK rise shifts mosi in.
   always @(posedge flash_sck or negedge flash_cs_n) begin
      if (flash_sck) begin
         cap      = {cap[TOT-2:0], flash_mosi};
         rise_cnt = rise_cnt + 1;
      end else begin
         cap      = '0;
         rise_cnt = 0;
      end
   end

   // Data bits are presented after the falling edge that ends the header.
   always @(negedge flash_sck)
      if (rise_cnt >= HDR && rise_cnt < TOT) flash_miso = flash_data[TOT-1-rise_cnt];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int bound, output logic [NUM_REQ-1:0] g,
                           output int gcyc, output bit ok);
      ok = 0; g = '0; gcyc = 0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (gnt != '0) begin g = gnt; gcyc = cyc; ok = 1; break; end
      end
   endtask

   // Called in the grant cycle; walks to rsp_valid measuring the SCK/mosi waveform.
   task automatic wait_rsp(input int bound, output int rcyc, output int rises,
                           output int bad_runs, output int mosi_bad, output int cs_hi,
                           output int gnt_seen, output bit ok);
      logic prev_sck, prev_mosi;
      bit   in_cs;
      int   run_len;
      ok = 0; rcyc = 0; rises = 0; bad_runs = 0; mosi_bad = 0; cs_hi = 0; gnt_seen = 0;
      prev_sck = 1'b0; prev_mosi = flash_mosi; in_cs = 1; run_len = 1;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (gnt != '0) gnt_seen++;
         if (flash_cs_n) cs_hi++;
         if (in_cs) begin
            if (!flash_cs_n && flash_sck == prev_sck) run_len++;
            else begin
               if (run_len != (prev_sck ? DUTY : CLK_PERIOD - DUTY)) bad_runs++;
               run_len = 1;
            end
         end
         if (!flash_cs_n && flash_sck && !prev_sck) rises++;
         if (!flash_cs_n && flash_sck && flash_mosi !== prev_mosi) mosi_bad++;
         prev_sck = flash_sck; prev_mosi = flash_mosi; in_cs = !flash_cs_n;
         if (rsp_valid) begin rcyc = cyc; ok = 1; break; end
      end
   endtask

   task automatic test_reset();
      repeat (2) tick();
      checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
      checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (flash_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", flash_cs_n); end
      checks++; if (flash_sck !== 1'b0 || flash_mosi !== 1'b0) begin
         errors++; $display("FAIL reset_sck_mosi: got %b%b want 00", flash_sck, flash_mosi); end
      reset = 1'b0;
      repeat (3) tick();
      checks++; if (flash_cs_n !== 1'b1 || busy !== 1'b0 || gnt !== '0) begin
         errors++; $display("FAIL idle_no_req: got cs_n=%b busy=%b gnt=%b want 1 0 00", flash_cs_n, busy, gnt); end
   endtask

   task automatic test_single();
      logic [NUM_REQ-1:0] g; int gc, rc, rises, br, mb, ch, gs; bit ok; exp_t e;
      flash_data = 32'hDEADBEEF;
      req_addr[0 +: ADDR_W] = 24'h123456;
      req = 2'b01;
      wait_gnt(20, g, gc, ok);
      req = '0;
      checks++; if (!ok || g !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", g); end
      if (!ok) return;
      e.id = 0; e.data = 32'hDEADBEEF; e.addr = 24'h123456; e.due = gc + LAT;
      sb.push_back(e);
      tb_rr = 1;
      checks++; if (busy !== 1'b1 || flash_cs_n !== 1'b0) begin
         errors++; $display("FAIL single_start: got busy=%b cs_n=%b want 1 0", busy, flash_cs_n); end
      wait_rsp(LAT + 20, rc, rises, br, mb, ch, gs, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_rsp_timeout: got none want rsp_valid"); return; end
      e = sb.pop_front();
      checks++; if (rc != e.due) begin errors++; $display("FAIL single_latency: got %0d want %0d", rc - gc, LAT); end
      checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL single_data: got %h want %h", rsp_data, e.data); end
      checks++; if (int'(rsp_id) != e.id) begin errors++; $display("FAIL single_id: got %0d want %0d", rsp_id, e.id); end
      checks++; if (cap[TOT-1 -: 8] !== EXP_CMD) begin errors++; $display("FAIL single_cmd: got %h want %h", cap[TOT-1 -: 8], EXP_CMD); end
      checks++; if (cap[TOT-9 -: ADDR_W] !== e.addr) begin errors++; $display("FAIL single_addr: got %h want %h", cap[TOT-9 -: ADDR_W], e.addr); end
      checks++; if (rises != TOT) begin errors++; $display("FAIL sck_rises: got %0d want %0d", rises, TOT); end
      checks++; if (br != 0) begin errors++; $display("FAIL sck_duty: got %0d bad runs want 0", br); end
      checks++; if (mb != 0) begin errors++; $display("FAIL mosi_stable: got %0d changes while sck high want 0", mb); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [NUM_REQ-1:0] g; int gc, rc, rises, br, mb, ch, gs, prev_rc, exp_id; bit ok; exp_t e;
      req_addr = {24'h555555, 24'hAAAAAA};
      req = 2'b11;
      prev_rc = 0;
      for (int k = 0; k < 4; k++) begin
         flash_data = 32'hC0DE0000 + DATA_W'(k * 32'h1111);
         wait_gnt((k == 0) ? 20 : 5, g, gc, ok);
         exp_id = tb_rr;
         checks++; if (!ok || g !== (NUM_REQ'(1) << exp_id)) begin
            errors++; $display("FAIL rr_gnt%0d: got %b want %b", k, g, NUM_REQ'(1) << exp_id); end
         if (!ok) break;
         if (k > 0) begin
            checks++; if (gc != prev_rc + 1) begin
               errors++; $display("FAIL rr_gap%0d: got %0d want %0d", k, gc - prev_rc, 1); end
         end
         tb_rr = (exp_id + 1) % NUM_REQ;
         if (k == 3) req = '0;
         e.id = exp_id; e.data = flash_data; e.addr = req_addr[exp_id*ADDR_W +: ADDR_W]; e.due = gc + LAT;
         sb.push_back(e);
         wait_rsp(LAT + 20, rc, rises, br, mb, ch, gs, ok);
         checks++; if (!ok) begin errors++; $display("FAIL rr_rsp_timeout%0d: got none want rsp_valid", k); break; end
         e = sb.pop_front();
         checks++; if (rc != e.due || rsp_data !== e.data || int'(rsp_id) != e.id) begin
            errors++; $display("FAIL rr_rsp%0d: got lat=%0d data=%h id=%0d want lat=%0d data=%h id=%0d",
                               k, rc - gc, rsp_data, rsp_id, LAT, e.data, e.id); end
         checks++; if (cap[TOT-9 -: ADDR_W] !== e.addr) begin
            errors++; $display("FAIL rr_addr%0d: got %h want %h", k, cap[TOT-9 -: ADDR_W], e.addr); end
         checks++; if (ch < 2) begin errors++; $display("FAIL rr_cs_high%0d: got %0d want >=2", k, ch); end
         prev_rc = rc;
      end
      req = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      logic [NUM_REQ-1:0] g; int gc, rc, rises, br, mb, ch, gs, stray; bit ok; exp_t e;
      req_addr[0 +: ADDR_W] = 24'h0F0F0F;
      req = 2'b01;
      wait_gnt(20, g, gc, ok);
      req = '0;
      checks++; if (!ok || g !== 2'b01) begin errors++; $display("FAIL rstmid_gnt: got %b want 01", g); end
      repeat (130) tick();
      reset = 1'b1;
      tick();
      checks++; if (flash_cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_n: got %b want 1", flash_cs_n); end
      checks++; if (flash_sck !== 1'b0) begin errors++; $display("FAIL rstmid_sck: got %b want 0", flash_sck); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      reset = 1'b0;
      tb_rr = 0;
      stray = 0;
      for (int i = 0; i < LAT; i++) begin
         tick();
         if (rsp_valid || gnt != '0) stray++;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_abandon: got %0d stray pulses want 0", stray); end
      flash_data = 32'h13579BDF;
      req_addr = {24'h222222, 24'h111111};
      req = 2'b11;
      wait_gnt(20, g, gc, ok);
      req = '0;
      checks++; if (!ok || g !== 2'b01) begin errors++; $display("FAIL rstmid_rr0: got %b want 01", g); end
      if (!ok) return;
      tb_rr = 1;
      e.id = 0; e.data = flash_data; e.addr = 24'h111111; e.due = gc + LAT;
      sb.push_back(e);
      wait_rsp(LAT + 20, rc, rises, br, mb, ch, gs, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_rsp_timeout: got none want rsp_valid"); return; end
      e = sb.pop_front();
      checks++; if (rc != e.due || rsp_data !== e.data || int'(rsp_id) != e.id) begin
         errors++; $display("FAIL rstmid_rsp: got lat=%0d data=%h id=%0d want lat=%0d data=%h id=%0d",
                            rc - gc, rsp_data, rsp_id, LAT, e.data, e.id); end
      tick();
   endtask

   task automatic test_drop_req();
      logic [NUM_REQ-1:0] g; int gc, rc, rises, br, mb, ch, gs, stray; bit ok; exp_t e;
      flash_data = 32'h0F1E2D3C;
      req_addr[ADDR_W +: ADDR_W] = 24'hABCDEF;
      req = 2'b10;
      wait_gnt(20, g, gc, ok);
      checks++; if (!ok || g !== 2'b10) begin errors++; $display("FAIL drop_gnt: got %b want 10", g); end
      if (!ok) begin req = '0; return; end
      tb_rr = 0;
      e.id = 1; e.data = flash_data; e.addr = 24'hABCDEF; e.due = gc + LAT;
      sb.push_back(e);
      tick();
      req = '0;
      wait_rsp(LAT + 20, rc, rises, br, mb, ch, gs, ok);
      checks++; if (!ok) begin errors++; $display("FAIL drop_rsp_timeout: got none want rsp_valid"); return; end
      e = sb.pop_front();
      checks++; if (rc != e.due || rsp_data !== e.data || int'(rsp_id) != e.id) begin
         errors++; $display("FAIL drop_rsp: got lat=%0d data=%h id=%0d want lat=%0d data=%h id=%0d",
                            rc - gc, rsp_data, rsp_id, LAT, e.data, e.id); end
      stray = gs;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (gnt != '0) stray++;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL drop_second_gnt: got %0d want 0", stray); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_mid();
      test_drop_req();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
